bist_result_monitor: RTL and testbench

BIST_RESULT_MONITOR -- requirements
Module: bist_result_monitor

---
 rtl/bist_result_monitor.sv | 134 +++++++++++++
 tb/tb_bist_result_monitor.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bist_result_monitor.sv
// Purpose: counts per-pattern BIST results over one run and records failing pattern indices in a small FIFO.
// Latency: counters, FIFO and run status update on the edge after the bistdone rising edge; rd_idx/rd_valid are combinational from registers.
// Backpressure: none toward the BIST controller; a fail index that meets a full FIFO (with no pop that cycle) is dropped and fifo_ovf is set.
// Ports: clk, rst (async active-low) | bistmode, bistdone, bistpass from the BIST controller
//        rd_req -> rd_valid, rd_idx fail-index read port | pat_cnt, fail_cnt, fifo_ovf, mon_done, mon_pass run status
module bist_result_monitor #(
  parameter int NUM_PAT    = 2000,
  parameter int IDX_W      = 11,
  parameter int FIFO_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bistmode,
  input  logic             bistdone,
  input  logic             bistpass,
  input  logic             rd_req,
  output logic             rd_valid,
  output logic [IDX_W-1:0] rd_idx,
  output logic [IDX_W:0]   pat_cnt,
  output logic [IDX_W:0]   fail_cnt,
  output logic             fifo_ovf,
  output logic             mon_done,
  output logic             mon_pass
);

  localparam int             AW         = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [IDX_W:0] LP_LAST    = (IDX_W+1)'(NUM_PAT);
  localparam logic [IDX_W:0] LP_ONE     = (IDX_W+1)'(1);
  localparam logic [IDX_W:0] LP_FMAX    = '1;
  localparam logic [AW:0]    LP_PTR_ONE = (AW+1)'(1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_bistdone_q;
  logic [IDX_W:0]   r_pat_cnt;
  logic [IDX_W:0]   r_fail_cnt;
  logic             r_fifo_ovf;
  logic [IDX_W-1:0] r_mem [FIFO_DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;

  logic w_event;
  logic w_start;
  logic w_count;
  logic w_fail;
  logic w_last;
  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;

  // A multi-cycle high strobe is a single result: only its rising edge counts.
  assign w_event = bistdone & ~r_bistdone_q;
  assign w_start = (r_state == S_IDLE) & bistmode;
  // Abort (bistmode low in RUN) takes priority over a coincident result.
  assign w_count = (r_state == S_RUN) & bistmode & w_event;
  assign w_fail  = w_count & ~bistpass;
  assign w_last  = w_count & ((r_pat_cnt + LP_ONE) == LP_LAST);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // A run start flushes the FIFO, which overrides any pop in that cycle.
  assign w_pop   = rd_req & ~w_empty & ~w_start;
  // On a full FIFO a same-cycle pop frees the head slot, so the push still lands.
  assign w_push  = w_fail & (~w_full | w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (bistmode) w_state_nxt = S_RUN;
      S_RUN: begin
        if (!bistmode) begin
          w_state_nxt = S_IDLE;
        end else if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: if (!bistmode) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bistdone_q <= 1'b0;
      r_pat_cnt    <= '0;
      r_fail_cnt   <= '0;
      r_fifo_ovf   <= 1'b0;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
    end else begin
      r_bistdone_q <= bistdone;
      if (w_start) begin
        r_pat_cnt  <= '0;
        r_fail_cnt <= '0;
        r_fifo_ovf <= 1'b0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
      end else begin
        if (w_count) r_pat_cnt <= r_pat_cnt + LP_ONE;
        if (w_fail && (r_fail_cnt != LP_FMAX)) r_fail_cnt <= r_fail_cnt + LP_ONE;
        if (w_fail && w_full && !w_pop) r_fifo_ovf <= 1'b1;
        if (w_push) r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
        if (w_pop) r_rd_ptr <= r_rd_ptr + LP_PTR_ONE;
      end
    end
  end

  // Storage needs no reset: rd_idx is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= r_pat_cnt[IDX_W-1:0];
  end

  assign rd_valid = ~w_empty;
  assign rd_idx   = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
  assign pat_cnt  = r_pat_cnt;
  assign fail_cnt = r_fail_cnt;
  assign fifo_ovf = r_fifo_ovf;
  assign mon_done = (r_state == S_DONE);
  // fail_cnt already includes the final result on the edge that enters DONE.
  assign mon_pass = (r_state == S_DONE) && (r_fail_cnt == '0);

endmodule

// File: tb/tb_bist_result_monitor.sv
module tb_bist_result_monitor;

  localparam int NUM_PAT  = 12;
  localparam int IDX_W    = 5;
  localparam int DEPTH    = 8;
  localparam int FAIL_MAX = (1 << (IDX_W + 1)) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             bistmode = 1'b0;
  logic             bistdone = 1'b0;
  logic             bistpass = 1'b0;
  logic             rd_req = 1'b0;
  logic             rd_valid;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W:0]   pat_cnt;
  logic [IDX_W:0]   fail_cnt;
  logic             fifo_ovf;
  logic             mon_done;
  logic             mon_pass;

  int n_checks = 0;
  int n_errs   = 0;
  int rd_prob  = 0;

  // Reference model: run/done flags, plain integer counters and a queue of fail indices.
  bit m_run, m_done, m_ovf, m_prev;
  int m_pat, m_fail;
  int m_q[$];

  bist_result_monitor #(
    .NUM_PAT   (NUM_PAT),
    .IDX_W     (IDX_W),
    .FIFO_DEPTH(DEPTH)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bistmode(bistmode),
    .bistdone(bistdone),
    .bistpass(bistpass),
    .rd_req  (rd_req),
    .rd_valid(rd_valid),
    .rd_idx  (rd_idx),
    .pat_cnt (pat_cnt),
    .fail_cnt(fail_cnt),
    .fifo_ovf(fifo_ovf),
    .mon_done(mon_done),
    .mon_pass(mon_pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_run = 0; m_done = 0; m_ovf = 0; m_prev = 0;
    m_pat = 0; m_fail = 0;
    m_q.delete();
  endfunction

  function automatic void model_edge();
    bit ev, can_pop, full0;
    ev      = bistdone && !m_prev;
    can_pop = rd_req && (m_q.size() > 0);
    full0   = (m_q.size() >= DEPTH);
    if (!m_run && !m_done && bistmode) begin
      m_run = 1; m_pat = 0; m_fail = 0; m_ovf = 0;
      m_q.delete();
    end else begin
      if (can_pop) void'(m_q.pop_front());
      if (m_run && !bistmode) begin
        m_run = 0;
      end else if (m_run && ev) begin
        if (!bistpass) begin
          m_fail = (m_fail < FAIL_MAX) ? m_fail + 1 : FAIL_MAX;
          if (!full0 || can_pop) m_q.push_back(m_pat % (1 << IDX_W));
          else m_ovf = 1;
        end
        m_pat++;
        if (m_pat == NUM_PAT) begin
          m_run = 0;
          m_done = 1;
        end
      end else if (m_done && !bistmode) begin
        m_done = 0;
      end
    end
    m_prev = bistdone;
  endfunction

  task automatic check_outputs(input string ph);
    int exp_idx;
    exp_idx = (m_q.size() > 0) ? m_q[0] : 0;
    chk({ph, ".rd_valid"}, 32'(rd_valid), 32'(m_q.size() > 0));
    chk({ph, ".rd_idx"},   32'(rd_idx),   exp_idx);
    chk({ph, ".pat_cnt"},  32'(pat_cnt),  m_pat);
    chk({ph, ".fail_cnt"}, 32'(fail_cnt), m_fail);
    chk({ph, ".fifo_ovf"}, 32'(fifo_ovf), 32'(m_ovf));
    chk({ph, ".mon_done"}, 32'(mon_done), 32'(m_done));
    chk({ph, ".mon_pass"}, 32'(mon_pass), 32'(m_done && (m_fail == 0)));
  endtask

  // Called at a negedge: drive rd_req, run one edge through DUT and model, check at the next negedge.
  task automatic cycle();
    rd_req = ($urandom_range(99) < rd_prob);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs("cyc");
  endtask

  task automatic pulse(input bit pass, input int hi, input int gap);
    bistdone = 1'b1;
    bistpass = pass;
    for (int i = 0; i < hi; i++) cycle();
    bistdone = 1'b0;
    bistpass = 1'($urandom_range(1));
    for (int i = 0; i < gap; i++) cycle();
  endtask

  task automatic restart();
    bistmode = 1'b0;
    cycle();
    bistmode = 1'b1;
    cycle();
  endtask

  initial begin
    model_reset();
    @(negedge clk);
    check_outputs("reset");
    rst = 1'b1;

    // Full passing run, then results ignored in DONE, then release to IDLE.
    rd_prob = 0;
    bistmode = 1'b1;
    cycle();
    for (int i = 0; i < NUM_PAT; i++) pulse(1'b1, 1, 1);
    chk("allpass.done", 32'(mon_done), 1);
    chk("allpass.pass", 32'(mon_pass), 1);
    chk("allpass.pat",  32'(pat_cnt), NUM_PAT);
    pulse(1'b0, 1, 1);
    bistmode = 1'b0;
    cycle();
    chk("allpass.idle_done", 32'(mon_done), 0);
    chk("allpass.held_pat",  32'(pat_cnt), NUM_PAT);

    // Failures at indices 1 and 3, popped while in DONE.
    bistmode = 1'b1;
    cycle();
    for (int i = 0; i < NUM_PAT; i++) pulse(!(i == 1 || i == 3), 1, 1);
    chk("fail2.cnt",  32'(fail_cnt), 2);
    chk("fail2.pass", 32'(mon_pass), 0);
    chk("fail2.idx0", 32'(rd_idx), 1);
    rd_prob = 100;
    cycle();
    chk("fail2.idx1", 32'(rd_idx), 3);
    cycle();
    chk("fail2.empty", 32'(rd_valid), 0);
    rd_prob = 0;

    // Multi-cycle strobe, then abort and restart.
    restart();
    pulse(1'b1, 3, 1);
    chk("stretch.pat", 32'(pat_cnt), 1);
    pulse(1'b0, 2, 1);
    bistmode = 1'b0;
    cycle();
    chk("abort.pat",  32'(pat_cnt), 2);
    chk("abort.done", 32'(mon_done), 0);
    bistmode = 1'b1;
    cycle();
    chk("restart.pat", 32'(pat_cnt), 0);
    chk("restart.rdv", 32'(rd_valid), 0);

    // Overflow: every pattern fails, nothing read.
    for (int i = 0; i < NUM_PAT; i++) pulse(1'b0, 1, 1);
    chk("ovf.flag", 32'(fifo_ovf), 1);
    chk("ovf.fail", 32'(fail_cnt), NUM_PAT);
    for (int i = 0; i < DEPTH; i++) begin
      chk("ovf.idx", 32'(rd_idx), i);
      rd_prob = 100;
      cycle();
    end
    chk("ovf.drained", 32'(rd_valid), 0);
    rd_prob = 0;

    // Push and pop in the same cycle on a full FIFO.
    restart();
    for (int i = 0; i < DEPTH; i++) pulse(1'b0, 1, 1);
    bistdone = 1'b1;
    bistpass = 1'b0;
    rd_prob = 100;
    cycle();
    rd_prob = 0;
    bistdone = 1'b0;
    cycle();
    chk("pushpop.ovf",  32'(fifo_ovf), 0);
    chk("pushpop.head", 32'(rd_idx), 1);
    chk("pushpop.fail", 32'(fail_cnt), DEPTH + 1);

    // Reset mid-run takes effect without a clock edge.
    restart();
    pulse(1'b0, 1, 1);
    pulse(1'b1, 1, 1);
    pulse(1'b0, 1, 1);
    #1 rst = 1'b0;
    #1;
    model_reset();
    check_outputs("arst");
    chk("arst.pat", 32'(pat_cnt), 0);
    @(negedge clk);
    check_outputs("arst_hold");
    bistmode = 1'b0;
    rst = 1'b1;
    cycle();

    // Randomised soak.
    for (int n = 0; n < 1200; n++) begin
      if (n % 40 == 0) rd_prob = $urandom_range(60);
      if ($urandom_range(19) == 0) bistmode = ~bistmode;
      pulse($urandom_range(3) != 0, $urandom_range(1, 3), $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
